// File: rtl/iir_acc.sv
// iir_acc: output accumulator of the IIR biquad section.
// Forms y(n) = round((X - P) / 2^SHIFT), saturates it to FB_W bits for the
// pole-stage feedback, and derives the OUT_W-bit audio sample from it.
// One sample takes three cycles: IDLE (capture difference) -> DIFF (round,
// clamp) -> SCALE (audio sample, flags, counter).
module iir_acc #(
    parameter int IN_W  = 48,
    parameter int FB_W  = 29,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  Xin,
    input  logic signed [IN_W-1:0]  Pin,
    input  logic                    clr,
    output logic signed [FB_W-1:0]  y_fb,
    output logic signed [OUT_W-1:0] dout,
    output logic                    out_valid,
    output logic                    sat_flag,
    output logic                    overrun,
    output logic [15:0]             sat_cnt
);

    // Two guard bits make X - P overflow-free, including the rounding offset.
    localparam int D_W = IN_W + 2;

    localparam logic signed [D_W-1:0] HALF =
        {{(D_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [D_W-1:0] FB_MAX =
        {{(D_W-FB_W+1){1'b0}}, {(FB_W-1){1'b1}}};
    localparam logic signed [D_W-1:0] FB_MIN =
        {{(D_W-FB_W+1){1'b1}}, {(FB_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIFF  = 2'd1,
        SCALE = 2'd2
    } state_t;

    // Sign-extend an input sum to the difference width.
    function automatic logic signed [D_W-1:0] sext(input logic signed [IN_W-1:0] v);
        return {{(D_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    // Round half toward +inf, then drop the SHIFT fractional bits.
    function automatic logic signed [D_W-1:0] round_shift(input logic signed [D_W-1:0] v);
        return (v + HALF) >>> SHIFT;
    endfunction

    // True when the rounded value lies outside the feedback range.
    function automatic logic sat_hit(input logic signed [D_W-1:0] r);
        return (r > FB_MAX) || (r < FB_MIN);
    endfunction

    // Clamp the rounded value into the feedback range.
    function automatic logic signed [FB_W-1:0] sat_clamp(input logic signed [D_W-1:0] r);
        if (r > FB_MAX) begin
            return FB_MAX[FB_W-1:0];
        end else if (r < FB_MIN) begin
            return FB_MIN[FB_W-1:0];
        end
        return r[FB_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic signed [D_W-1:0]   d_q, d_d;
    logic signed [D_W-1:0]   rnd;
    logic signed [FB_W-1:0]  y_fb_q, y_fb_d;
    logic signed [OUT_W-1:0] dout_q, dout_d;
    logic                    clip_q, clip_d;
    logic                    sat_flag_q, sat_flag_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             sat_cnt_q, sat_cnt_d;

    assign rnd = round_shift(d_q);

    // Next-state and datapath updates for the IDLE -> DIFF -> SCALE sequence.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        y_fb_d      = y_fb_q;
        dout_d      = dout_q;
        clip_d      = clip_q;
        sat_flag_d  = sat_flag_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        sat_cnt_d   = sat_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d     = sext(Xin) - sext(Pin);
                    state_d = DIFF;
                end
            end
            DIFF: begin
                y_fb_d  = sat_clamp(rnd);
                clip_d  = sat_hit(rnd);
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
                state_d = SCALE;
            end
            SCALE: begin
                // Top OUT_W bits of y_fb are exactly y_fb >>> (FB_W - OUT_W).
                dout_d      = y_fb_q[FB_W-1 -: OUT_W];
                sat_flag_d  = clip_q;
                out_valid_d = 1'b1;
                if (clip_q && (sat_cnt_q != 16'hFFFF)) begin
                    sat_cnt_d = sat_cnt_q + 16'd1;
                end
                if (in_valid) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear has priority over a same-cycle increment or overrun event.
        if (clr) begin
            sat_cnt_d = '0;
            overrun_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            y_fb_q      <= '0;
            dout_q      <= '0;
            clip_q      <= 1'b0;
            sat_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            sat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            y_fb_q      <= y_fb_d;
            dout_q      <= dout_d;
            clip_q      <= clip_d;
            sat_flag_q  <= sat_flag_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign y_fb      = y_fb_q;
    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_flag_q;
    assign overrun   = overrun_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_iir_acc.sv
// Directed bench for iir_acc: table of single samples with hand-computed
// results, plus sequences for overrun, counter limits, clear and reset.
module tb_iir_acc;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic signed [47:0]  Xin;
    logic signed [47:0]  Pin;
    logic                clr;
    logic signed [28:0]  y_fb;
    logic signed [15:0]  dout;
    logic                out_valid;
    logic                sat_flag;
    logic                overrun;
    logic [15:0]         sat_cnt;

    int nvec = 0;
    int nerr = 0;

    iir_acc #(
        .IN_W (48),
        .FB_W (29),
        .OUT_W(16),
        .SHIFT(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .Xin      (Xin),
        .Pin      (Pin),
        .clr      (clr),
        .y_fb     (y_fb),
        .dout     (dout),
        .out_valid(out_valid),
        .sat_flag (sat_flag),
        .overrun  (overrun),
        .sat_cnt  (sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic signed [47:0] x;
        logic signed [47:0] p;
        logic signed [28:0] y;
        logic signed [15:0] d;
        logic               s;
        logic [15:0]        c;
    } vec_t;

    vec_t vec[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One sample from strobe (cycle 0) through the cycle after out_valid.
    task automatic apply(input vec_t v, input string tag, input logic clr_scale);
        in_valid = 1'b1;
        Xin      = v.x;
        Pin      = v.p;
        step();
        in_valid = 1'b0;
        step();
        chk({tag, " y_fb"}, y_fb, v.y);
        chk({tag, " ov_c2"}, out_valid, 0);
        clr = clr_scale;
        step();
        clr = 1'b0;
        chk({tag, " ov_c3"}, out_valid, 1);
        chk({tag, " dout"}, dout, v.d);
        chk({tag, " sat_flag"}, sat_flag, v.s);
        chk({tag, " sat_cnt"}, sat_cnt, v.c);
        chk({tag, " y_hold"}, y_fb, v.y);
        step();
        chk({tag, " ov_c4"}, out_valid, 0);
    endtask

    logic signed [47:0] ovr_x[4];
    vec_t cv;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        clr      = 1'b0;
        Xin      = '0;
        Pin      = '0;

        vec[0]  = '{48'sd805306368, 48'sd0, 29'sd24576, 16'sd3, 1'b0, 16'd0};
        vec[1]  = '{48'sd16384, 48'sd0, 29'sd1, 16'sd0, 1'b0, 16'd0};
        vec[2]  = '{48'sd16383, 48'sd0, 29'sd0, 16'sd0, 1'b0, 16'd0};
        vec[3]  = '{-48'sd16384, 48'sd0, 29'sd0, 16'sd0, 1'b0, 16'd0};
        vec[4]  = '{-48'sd16385, 48'sd0, -29'sd1, -16'sd1, 1'b0, 16'd0};
        vec[5]  = '{48'sd32768000, -48'sd16384000, 29'sd1500, 16'sd0, 1'b0, 16'd0};
        vec[6]  = '{48'sh7FFF_FFFF_FFFF, 48'sh8000_0000_0000, 29'sh0FFF_FFFF,
                    16'sh7FFF, 1'b1, 16'd1};
        vec[7]  = '{48'sh8000_0000_0000, 48'sh7FFF_FFFF_FFFF, 29'sh1000_0000,
                    16'sh8000, 1'b1, 16'd2};
        vec[8]  = '{48'sd805306368, 48'sd0, 29'sd24576, 16'sd3, 1'b0, 16'd2};
        vec[9]  = '{48'sd8796092989440, 48'sd0, 29'sh0FFF_FFFF, 16'sh7FFF, 1'b0, 16'd2};
        vec[10] = '{48'sd8796093022208, 48'sd0, 29'sh0FFF_FFFF, 16'sh7FFF, 1'b1, 16'd3};
        vec[11] = '{-48'sd8796093022208, 48'sd0, 29'sh1000_0000, 16'sh8000, 1'b0, 16'd3};
        vec[12] = '{-48'sd8796093038593, 48'sd0, 29'sh1000_0000, 16'sh8000, 1'b1, 16'd4};

        ovr_x[0] = 48'sd805306368;
        ovr_x[1] = 48'sd1099511627776;
        ovr_x[2] = -48'sd1099511627776;
        ovr_x[3] = 48'sd2684354560;

        // Reset state
        step();
        step();
        chk("rst y_fb", y_fb, 0);
        chk("rst dout", dout, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst sat_flag", sat_flag, 0);
        chk("rst overrun", overrun, 0);
        chk("rst sat_cnt", sat_cnt, 0);
        rst = 1'b0;
        step();

        // Single samples: nominal, rounding, saturation, range edges
        for (int i = 0; i < 13; i++) begin
            apply(vec[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Back-to-back strobes: only cycle-0 and cycle-3 samples survive
        for (int c = 0; c <= 9; c++) begin
            chk($sformatf("ovr c%0d out_valid", c), out_valid, (c == 3 || c == 6));
            chk($sformatf("ovr c%0d overrun", c), overrun, (c >= 2 && c <= 8));
            if (c == 2) chk("ovr y_fb A", y_fb, 24576);
            if (c == 3) chk("ovr dout A", dout, 3);
            if (c == 3) chk("ovr sat_flag A", sat_flag, 0);
            if (c == 5) chk("ovr y_fb D", y_fb, 81920);
            if (c == 6) chk("ovr dout D", dout, 10);
            if (c == 9) chk("ovr clr sat_cnt", sat_cnt, 0);
            in_valid = (c <= 3);
            if (c <= 3) Xin = ovr_x[c];
            else        Xin = '0;
            Pin = '0;
            clr = (c == 8);
            step();
        end
        clr = 1'b0;

        // Counter limit: preload just below the top, then two clipped samples
        force dut.sat_cnt_q = 16'hFFFE;
        step();
        release dut.sat_cnt_q;
        chk("lim preload", sat_cnt, 16'hFFFE);
        cv   = vec[6];
        cv.c = 16'hFFFF;
        apply(cv, "lim reach", 1'b0);
        apply(cv, "lim hold", 1'b0);

        // Clear coinciding with a clipped sample's SCALE cycle
        cv.c = 16'd0;
        apply(cv, "clr_scale", 1'b1);
        cv.c = 16'd1;
        apply(cv, "post_clr", 1'b0);

        // Reset mid-sample, strobe during reset ignored, then a normal sample
        for (int c = 0; c <= 7; c++) begin
            chk($sformatf("rstseq c%0d out_valid", c), out_valid, (c == 7));
            if (c == 2) begin
                chk("rstseq y_fb", y_fb, 0);
                chk("rstseq dout", dout, 0);
                chk("rstseq sat_flag", sat_flag, 0);
                chk("rstseq overrun", overrun, 0);
                chk("rstseq sat_cnt", sat_cnt, 0);
            end
            if (c == 6) chk("rstseq y_fb new", y_fb, 24576);
            if (c == 7) chk("rstseq dout new", dout, 3);
            in_valid = (c == 0 || c == 1 || c == 4);
            rst      = (c == 1);
            Xin      = (c == 4) ? 48'sd805306368 : 48'sd1099511627776;
            Pin      = '0;
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        chk("rstseq ov_end", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
